// File: rtl/compute_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : compute_dispatcher
// Brief    : FIFO-queued command dispatcher; issues one command at a time to a
//            compute unit and forwards its result to a transmitter.
//            Optional WAIT timeout is built when DISPATCH_TIMEOUT_EN is defined.
// Revision : 1.0
// ============================================================================
module compute_dispatcher #(
    parameter int DATA_W      = 128,
    parameter int NUM_UNITS   = 4,
    parameter int OP_W        = 3,
    parameter int QDEPTH      = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           rx_data,
    input  logic [OP_W-1:0]             rx_op,
    input  logic                        rx_irq,
    output logic [NUM_UNITS-1:0]        unit_start,
    output logic [DATA_W-1:0]           unit_operand,
    input  logic [NUM_UNITS-1:0]        unit_done,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_result,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_wr,
    input  logic                        tx_busy,
    output logic                        busy,
    output logic                        q_full,
    output logic                        overflow,
    output logic                        err_op,
    output logic                        err_timeout
);

    localparam int c_sel_w = $clog2(NUM_UNITS);
    localparam int c_aw    = $clog2(QDEPTH);
    localparam int c_ew    = OP_W + DATA_W;

    generate
        if (NUM_UNITS < 2 || NUM_UNITS > 8 || NUM_UNITS > (1 << OP_W)) begin : g_chk_units
            $error("compute_dispatcher: NUM_UNITS out of range");
        end
        if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_chk_qdepth
            $error("compute_dispatcher: QDEPTH must be a power of two >= 2");
        end
        if (TIMEOUT_CYC < 1) begin : g_chk_timeout
            $error("compute_dispatcher: TIMEOUT_CYC must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_sel_w-1:0] r_sel;
    logic [c_ew-1:0]    r_mem [QDEPTH];
    logic [c_aw:0]      r_wptr;
    logic [c_aw:0]      r_rptr;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [c_ew-1:0]    w_head;
    logic [OP_W-1:0]    w_head_op;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_head_bad;
    logic [DATA_W-1:0]  w_sel_result;
    logic               w_sel_done;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                         (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_pop       = (r_state == IDLE) && !w_empty;
    assign w_push      = rx_irq && (!w_full || w_pop);
    assign w_head      = r_mem[r_rptr[c_aw-1:0]];
    assign w_head_op   = w_head[c_ew-1 -: OP_W];
    assign w_head_data = w_head[DATA_W-1:0];
    assign w_head_bad  = ({1'b0, w_head_op} >= (OP_W+1)'(NUM_UNITS));

    assign busy   = (r_state != IDLE) || !w_empty;
    assign q_full = w_full;

    always_comb begin
        w_sel_result = '0;
        w_sel_done   = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (r_sel == c_sel_w'(k)) begin
                w_sel_result = unit_result[k*DATA_W +: DATA_W];
                w_sel_done   = unit_done[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[c_aw-1:0]] <= {rx_op, rx_data};
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);
    logic [c_cnt_w-1:0] r_wait_cnt;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            unit_start   <= '0;
            unit_operand <= '0;
            tx_data      <= '0;
            tx_wr        <= 1'b0;
            overflow     <= 1'b0;
            err_op       <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            err_timeout  <= 1'b0;
            r_wait_cnt   <= '0;
`endif
        end else begin
            unit_start <= '0;
            tx_wr      <= 1'b0;
            err_op     <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (rx_irq && !w_push) overflow <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        if (w_head_bad) begin
                            err_op <= 1'b1;
                        end else begin
                            r_sel        <= w_head_op[c_sel_w-1:0];
                            unit_operand <= w_head_data;
                            r_state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    unit_start <= NUM_UNITS'(1) << r_sel;
                    r_state    <= WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (w_sel_done) begin
                        tx_data <= w_sel_result;
                        r_state <= SEND;
                    end
`ifdef DISPATCH_TIMEOUT_EN
                    else if (r_wait_cnt == c_cnt_last) begin
                        err_timeout <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_wr   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_compute_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_compute_dispatcher
// Brief    : Directed self-checking bench for compute_dispatcher (default build
//            or DISPATCH_TIMEOUT_EN build with TIMEOUT_CYC=50).
// Revision : 1.0
// ============================================================================
module tb_compute_dispatcher;

    localparam int DATA_W = 128;
    localparam int NU     = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] rx_data = '0;
    logic [2:0]        rx_op = '0;
    logic              rx_irq = 1'b0;
    logic [NU-1:0]     unit_start;
    logic [DATA_W-1:0] unit_operand;
    logic [NU-1:0]     unit_done = '0;
    logic [NU*DATA_W-1:0] unit_result = '0;
    logic [DATA_W-1:0] tx_data;
    logic              tx_wr;
    logic              tx_busy = 1'b0;
    logic              busy, q_full, overflow, err_op, err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int st_cnt  = 0;
    int eo_cnt  = 0;

    compute_dispatcher #(
        .DATA_W(DATA_W), .NUM_UNITS(NU), .OP_W(3), .QDEPTH(4), .TIMEOUT_CYC(50)
    ) dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_op(rx_op), .rx_irq(rx_irq),
        .unit_start(unit_start), .unit_operand(unit_operand),
        .unit_done(unit_done), .unit_result(unit_result),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .busy(busy), .q_full(q_full), .overflow(overflow),
        .err_op(err_op), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (tx_wr)            wr_cnt++;
        if (unit_start != '0) st_cnt++;
        if (err_op)           eo_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [DATA_W-1:0] d);
        rx_op   = op;
        rx_data = d;
        rx_irq  = 1'b1;
        tick();
        rx_irq  = 1'b0;
    endtask

    task automatic wait_start();
        int t = 0;
        while (unit_start == '0 && t < 60) begin tick(); t++; end
    endtask

    task automatic wait_wr();
        int t = 0;
        while (!tx_wr && t < 60) begin tick(); t++; end
    endtask

    // Emulates one unit: expects its start, replies two cycles later.
    task automatic serve(input string tag, input int u, input logic [DATA_W-1:0] opnd,
                         input logic [DATA_W-1:0] res);
        wait_start();
        check({tag, " start"}, DATA_W'(unit_start), DATA_W'(1 << u));
        check({tag, " operand"}, unit_operand, opnd);
        tick();
        tick();
        unit_done = NU'(1 << u);
        unit_result[u*DATA_W +: DATA_W] = res;
        tick();
        unit_done = '0;
        wait_wr();
        check({tag, " tx_wr"}, DATA_W'(tx_wr), 1);
        check({tag, " tx_data"}, tx_data, res);
        tick();
    endtask

    initial begin
        int w0, s0, e0;
        logic stable_ok;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst unit_start", DATA_W'(unit_start), 0);
        check("rst unit_operand", unit_operand, 0);
        check("rst tx_data", tx_data, 0);
        check("rst flags", DATA_W'({tx_wr, overflow, err_op, err_timeout, busy, q_full}), 0);

        // Single command with latency, ISSUE-cycle done and foreign done ignored
        push(3'd1, 128'h11);
        check("lat c0 start", DATA_W'(unit_start), 0);
        check("lat c0 busy", DATA_W'(busy), 1);
        tick();
        check("lat issue operand", unit_operand, 128'h11);
        check("lat issue start", DATA_W'(unit_start), 0);
        unit_done = 4'b0010;
        unit_result[1*DATA_W +: DATA_W] = 128'hBAD;
        tick();
        unit_done = '0;
        check("lat start N+2", DATA_W'(unit_start), 4'b0010);
        check("issue done ignored", tx_data, 0);
        tick();
        check("start one cycle", DATA_W'(unit_start), 0);
        unit_done = 4'b1101;
        tick();
        unit_done = '0;
        repeat (6) tick();
        check("foreign done ignored", tx_data, 0);
        check("no early wr", DATA_W'(wr_cnt), 0);
        unit_done = 4'b0010;
        unit_result[1*DATA_W +: DATA_W] = 128'hAD5;
        tick();
        unit_done = '0;
        check("M+1 no wr", DATA_W'(tx_wr), 0);
        check("M+1 tx_data", tx_data, 128'hAD5);
        tick();
        check("M+2 tx_wr", DATA_W'(tx_wr), 1);
        tick();
        check("wr pulse end", DATA_W'(tx_wr), 0);
        check("single wr", DATA_W'(wr_cnt), 1);
        check("single start", DATA_W'(st_cnt), 1);
        check("idle busy", DATA_W'(busy), 0);
        check("tx_data retained", tx_data, 128'hAD5);

        // Transmitter back-pressure
        w0 = wr_cnt;
        push(3'd2, 128'h22);
        wait_start();
        check("bp start", DATA_W'(unit_start), 4'b0100);
        tx_busy = 1'b1;
        unit_done = 4'b0100;
        unit_result[2*DATA_W +: DATA_W] = 128'h1234;
        tick();
        unit_done = '0;
        stable_ok = 1'b1;
        repeat (20) begin
            tick();
            if (tx_wr || tx_data !== 128'h1234) stable_ok = 1'b0;
        end
        check("bp hold stable", DATA_W'(stable_ok), 1);
        tx_busy = 1'b0;
        tick();
        check("bp tx_wr", DATA_W'(tx_wr), 1);
        check("bp tx_data", tx_data, 128'h1234);
        tick();
        check("bp single wr", DATA_W'(wr_cnt - w0), 1);

        // Illegal opcode followed by a legal one
        e0 = eo_cnt;
        s0 = st_cnt;
        push(3'd6, 128'h66);
        push(3'd3, 128'h33);
        serve("after err_op", 3, 128'h33, 128'h333);
        check("err_op pulses", DATA_W'(eo_cnt - e0), 1);
        check("err_op no start", DATA_W'(st_cnt - s0), 1);

        // Overflow with a stalled unit; push during full-queue pop is accepted
        w0 = wr_cnt;
        s0 = st_cnt;
        push(3'd0, 128'h50);
        wait_start();
        push(3'd0, 128'hA0);
        push(3'd1, 128'hA1);
        push(3'd2, 128'hA2);
        push(3'd3, 128'hA3);
        push(3'd1, 128'hA4);
        check("ovf overflow", DATA_W'(overflow), 1);
        check("ovf q_full", DATA_W'(q_full), 1);
        unit_done = 4'b0001;
        unit_result[0 +: DATA_W] = 128'h5000;
        tick();
        unit_done = '0;
        wait_wr();
        check("ovf stalled tx", tx_data, 128'h5000);
        push(3'd2, 128'hA5);
        check("push on full pop", DATA_W'(q_full), 1);
        serve("q0", 0, 128'hA0, 128'h10A0);
        serve("q1", 1, 128'hA1, 128'h10A1);
        serve("q2", 2, 128'hA2, 128'h10A2);
        serve("q3", 3, 128'hA3, 128'h10A3);
        serve("q5", 2, 128'hA5, 128'h10A5);
        repeat (5) tick();
        check("ovf wr count", DATA_W'(wr_cnt - w0), 6);
        check("ovf dropped never issued", DATA_W'(st_cnt - s0), 6);
        check("ovf sticky", DATA_W'(overflow), 1);
        check("ovf idle", DATA_W'(busy), 0);

        // Unit that never completes
        w0 = wr_cnt;
        push(3'd2, 128'h99);
        wait_start();
`ifdef DISPATCH_TIMEOUT_EN
        begin
            int t = 0;
            while (!err_timeout && t < 100) begin tick(); t++; end
            check("timeout cycles", DATA_W'(t), 50);
            tick();
            check("timeout pulse", DATA_W'(err_timeout), 0);
            check("timeout idle", DATA_W'(busy), 0);
            check("timeout no wr", DATA_W'(wr_cnt - w0), 0);
        end
`else
        repeat (60) tick();
        check("no timeout busy", DATA_W'(busy), 1);
        check("no timeout flag", DATA_W'(err_timeout), 0);
        check("no timeout wr", DATA_W'(wr_cnt - w0), 0);
        unit_done = 4'b0100;
        unit_result[2*DATA_W +: DATA_W] = 128'h999;
        tick();
        unit_done = '0;
        wait_wr();
        check("late done tx", tx_data, 128'h999);
        tick();
`endif

        // Reset in WAIT with two queued entries
        push(3'd1, 128'h77);
        wait_start();
        push(3'd2, 128'h78);
        push(3'd3, 128'h79);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid rst unit_start", DATA_W'(unit_start), 0);
        check("mid rst operand", unit_operand, 0);
        check("mid rst tx_data", tx_data, 0);
        check("mid rst flags", DATA_W'({tx_wr, overflow, err_op, err_timeout, busy, q_full}), 0);
        w0 = wr_cnt;
        s0 = st_cnt;
        unit_done = 4'hF;
        tick();
        unit_done = '0;
        repeat (10) tick();
        check("post rst no wr", DATA_W'(wr_cnt - w0), 0);
        check("post rst no start", DATA_W'(st_cnt - s0), 0);
        check("post rst idle", DATA_W'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/compute_dispatcher.md
COMPUTE_DISPATCHER -- requirements
Module: compute_dispatcher

Interface
REQ-001 SHALL have parameter DATA_W, default 128: width of operand, result and tx words.
REQ-002 SHALL have parameter NUM_UNITS, default 4, range 2..8: number of compute-unit channels.
REQ-003 SHALL have parameter OP_W, default 3: opcode width; NUM_UNITS <= 2**OP_W.
REQ-004 SHALL have parameter QDEPTH, default 4, power of two: command queue depth.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65535: maximum WAIT cycles per command.
REQ-006 SHALL have ports, in order: clock  in  1  system clock; reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have rx_data  in  DATA_W  command operand; rx_op  in  OP_W  unit select; rx_irq  in  1  one-cycle command strobe.
REQ-008 SHALL have unit_start  out  NUM_UNITS  one-hot start pulse; unit_operand  out  DATA_W  operand to units.
REQ-009 SHALL have unit_done  in  NUM_UNITS  per-unit done; unit_result  in  NUM_UNITS*DATA_W  packed results, unit k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have tx_data  out  DATA_W  result word; tx_wr  out  1  one-cycle write strobe; tx_busy  in  1  transmitter busy.
REQ-011 SHALL have busy  out  1  FSM not IDLE or queue non-empty; q_full  out  1; overflow  out  1  sticky drop flag; err_op  out  1  pulse; err_timeout  out  1  pulse.

Function
REQ-012 SHALL queue {rx_op, rx_data} into a QDEPTH-entry FIFO on each clock edge with rx_irq high and queue not full.
REQ-013 SHALL drop rx_irq while full and set overflow, held until reset; a push in the same cycle as a pop while full SHALL be accepted.
REQ-014 SHALL have no FIFO bypass: a pushed entry is visible to the FSM the cycle after the write.
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, SEND.
REQ-016 IDLE: if queue non-empty, pop; rx_op >= NUM_UNITS -> err_op pulse for 1 cycle and remain IDLE; otherwise latch sel=rx_op, operand -> ISSUE.
REQ-017 ISSUE: unit_start[sel]=1 for exactly one cycle, unit_operand holds the latched operand from ISSUE until next pop -> WAIT.
REQ-018 WAIT: on unit_done[sel], capture unit_result slice sel into tx_data -> SEND; unit_done of unselected units SHALL be ignored.
REQ-019 unit_done[sel] asserted in ISSUE cycle SHALL NOT be accepted; only WAIT samples done.
REQ-020 SEND: when tx_busy low, tx_wr=1 for one cycle -> IDLE; while tx_busy high, hold in SEND, tx_data stable.
REQ-021 Latency, idle empty queue: rx_irq at edge N -> unit_start high during cycle N+2; unit_done at cycle M -> tx_wr at cycle M+2 with tx_busy low.
REQ-022 At most one command in flight; queued commands execute strictly in arrival order.
REQ-023 tx_data SHALL retain its last value outside SEND.

Reset
REQ-024 On reset: FSM IDLE, queue empty, unit_start=0, unit_operand=0, tx_data=0, tx_wr=0, overflow=0, err_op=0, err_timeout=0, busy=0, q_full=0.
REQ-025 Reset mid-operation SHALL discard in-flight and queued commands with no tx_wr; a later unit_done SHALL be ignored in IDLE.

Configuration
REQ-026 With DISPATCH_TIMEOUT_EN defined: WAIT cycle counter, cleared on entry; on reaching TIMEOUT_CYC without done, err_timeout pulses one cycle, FSM -> IDLE, no tx_wr.
REQ-027 Without DISPATCH_TIMEOUT_EN: no counter logic, WAIT waits indefinitely, err_timeout tied 0.

Verification
REQ-028 rx_op=1, rx_data=0x11; unit 1 done after 10 cycles with result 0xAD5 -> unit_start=4'b0010 one cycle, tx_data=0xAD5, single tx_wr.
REQ-029 5 back-to-back rx_irq, QDEPTH=4, units stalled -> overflow=1, q_full=1, 4 results emitted in order after release, 5th never issued.
REQ-030 rx_op=6 with NUM_UNITS=4 -> err_op one-cycle pulse, no unit_start, next queued command runs normally.
REQ-031 Result ready with tx_busy held high 20 cycles -> tx_wr exactly at first cycle tx_busy low, tx_data unchanged throughout.
REQ-032 DISPATCH_TIMEOUT_EN, TIMEOUT_CYC=50, unit never done -> err_timeout after 50 WAIT cycles, FSM IDLE, no tx_wr; undefined -> stays WAIT.
REQ-033 Reset asserted in WAIT with 2 queued entries -> all outputs reset values, later unit_done produces no tx_wr.
